// File: rtl/maxfinder_pkg.sv
// maxfinder_pkg: definitions shared by the max-finder blocks.
//   - state_t : 2-bit binary state encoding used by the mem_loader FSM.
//   - MF_DATA_W / MF_ADDR_W : default data and RAM address widths, shared
//     with the max-finder controller and datapath.
package maxfinder_pkg;

  localparam int MF_DATA_W = 8;
  localparam int MF_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD      = 2'b01,
    ST_START     = 2'b10,
    ST_WAIT_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/load_addr_counter.sv
// load_addr_counter: write-address counter for the RAM loader.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears count
//   clear : synchronous clear to 0 (has priority over inc)
//   inc   : increment by one
//   count : current address
// The owner guarantees inc is never asserted at the top value, so the
// counter does not need wrap handling.
module load_addr_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + ADDR_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/mem_loader.sv
// mem_loader: upstream stage of the max-finder. Takes a valid/ready word
// stream, writes it into the data RAM at sequential addresses from 0,
// publishes the last written address, pulses mf_start and waits for
// mf_done before returning to idle.
// Optional build macro: MEM_LOADER_CHECKSUM_EN adds a checksum output
// (modulo-2^DATA_W sum of the words accepted in the current load).
// Ports:
//   clk, reset           : clock (rising edge), async active-low reset
//   load_go              : start a load (only looked at in IDLE)
//   in_data/in_valid/in_ready/in_last : input word stream
//   mem_we/mem_addr/mem_wdata : RAM write port (same cycle as accept)
//   last_addr            : address of the final word of the set
//   mf_start / mf_done   : handshake with the max-finder
//   busy                 : high whenever not IDLE
//   checksum             : (MEM_LOADER_CHECKSUM_EN only) running sum
module mem_loader
  import maxfinder_pkg::*;
#(
  parameter int DATA_W    = MF_DATA_W,
  parameter int ADDR_W    = MF_ADDR_W,
  parameter int LAST_ADDR = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_go,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] last_addr,
  output logic              mf_start,
  input  logic              mf_done,
  output logic              busy
`ifdef MEM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_mf_start;
  logic              r_busy;
  logic [ADDR_W-1:0] r_last_addr;

  logic              w_accept;
  logic              w_final;
  logic              w_clear;
  logic              w_inc;
  logic [ADDR_W-1:0] w_count;

  // r_in_ready is high exactly in LOAD, so it doubles as the LOAD decode.
  assign w_accept = r_in_ready & in_valid;
  // The counter stops at LAST_ADDR: that word closes the set regardless of in_last.
  assign w_final  = in_last | (w_count == ADDR_W'(LAST_ADDR));
  assign w_clear  = (r_state == ST_IDLE) & load_go;
  assign w_inc    = w_accept & ~w_final;

  load_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .inc   (w_inc),
    .count (w_count)
  );

  // Outputs are registered together with the state so they track it exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_mf_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_last_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_go) begin
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept && w_final) begin
            r_state     <= ST_START;
            r_in_ready  <= 1'b0;
            r_mf_start  <= 1'b1;
            r_last_addr <= w_count;
          end
        end
        ST_START: begin
          // mf_done is deliberately not looked at here.
          r_state    <= ST_WAIT_DONE;
          r_mf_start <= 1'b0;
        end
        ST_WAIT_DONE: begin
          if (mf_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_mf_start <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mf_start  = r_mf_start;
  assign busy      = r_busy;
  assign last_addr = r_last_addr;

  // RAM write is zero-latency: address and data come straight from the
  // counter and the stream in the accepting cycle.
  assign mem_we    = w_accept;
  assign mem_addr  = w_count;
  assign mem_wdata = in_data;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_clear) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + in_data;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_go;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] last_addr;
  logic              mf_start;
  logic              mf_done;
  logic              busy;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] words [0:31];

  always #5 clk = ~clk;

  mem_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_go   (load_go),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .last_addr (last_addr),
    .mf_start  (mf_start),
    .mf_done   (mf_done),
    .busy      (busy)
`ifdef MEM_LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full data set. gap_pct<0 selects the fixed valid pattern 1,0,0,1,0,1.
  // Expectations follow the set rules: word k goes to address k, the set
  // closes on in_last or on the 16th word, last_addr = words written - 1.
  task automatic run_load(input int len, input int gap_pct, input bit do_last,
                          input bit done_in_start, input int wait_cycles);
    int n_exp;
    int accepted;
    int cyc;
    bit v;
    bit fin;
    logic [DATA_W-1:0] sum;
    logic [ADDR_W-1:0] prev_last;
    n_exp = (do_last && len <= DEPTH) ? len : DEPTH;
    sum = '0;
    accepted = 0;
    cyc = 0;
    fin = 1'b0;
    load_go = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    in_last = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_no_write", mem_we, 0);
    chk("idle_busy", busy, 0);
    step();
    load_go = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    chk("cksum_cleared", checksum, 0);
    #1;
`endif
    while (!fin && cyc < 200) begin
      if (gap_pct < 0) v = (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5);
      else v = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = v ? words[accepted] : DATA_W'($urandom);
      in_last  = v ? (do_last && accepted == len - 1) : 1'($urandom_range(1));
      @(negedge clk);
      chk("load_in_ready", in_ready, 1);
      chk("load_busy", busy, 1);
      chk("load_mf_start", mf_start, 0);
      chk("load_mem_we", mem_we, v);
      if (v) begin
        chk("load_addr", mem_addr, accepted);
        chk("load_wdata", mem_wdata, words[accepted]);
      end
      step();
      if (v) begin
        sum = sum + words[accepted];
        accepted++;
        if ((do_last && accepted == len) || accepted == DEPTH) fin = 1'b1;
      end
      cyc++;
    end
    chk("load_count", accepted, n_exp);
    // START cycle: keep offering data, it must not be written.
    in_valid = 1'b1;
    in_last  = 1'b0;
    load_go  = 1'b1;
    mf_done  = done_in_start;
    @(negedge clk);
    chk("start_pulse", mf_start, 1);
    chk("start_in_ready", in_ready, 0);
    chk("start_no_write", mem_we, 0);
    chk("start_busy", busy, 1);
    chk("last_addr", last_addr, n_exp - 1);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
    prev_last = last_addr;
    step();
    mf_done = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      chk("wait_start_low", mf_start, 0);
      chk("wait_busy", busy, 1);
      chk("wait_no_write", mem_we, 0);
      step();
    end
    load_go = 1'b0;
    mf_done = 1'b1;
    @(negedge clk);
    chk("wait_busy_at_done", busy, 1);
    step();
    mf_done = 1'b0;
    @(negedge clk);
    chk("done_idle_busy", busy, 0);
    chk("done_in_ready", in_ready, 0);
    chk("last_addr_stable", last_addr, prev_last);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("cksum_hold", checksum, sum);
`endif
    step();
    @(negedge clk);
    chk("no_queued_load", busy, 0);
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0;
    load_go = 1'b0;
    in_data = '0;
    in_valid = 1'b1;
    in_last = 1'b0;
    mf_done = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mf_start", mf_start, 0);
    chk("rst_last_addr", last_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // in_valid in IDLE without load_go: nothing happens.
    @(negedge clk);
    chk("idle_ignore_valid", mem_we, 0);
    step();
    in_valid = 1'b0;

    // Full load 0x10..0x1F, no gaps.
    for (int i = 0; i < DEPTH; i++) words[i] = DATA_W'(8'h10 + i);
    run_load(16, 0, 1'b0, 1'b0, 1);

    // Early last: 3,9,1,7,4; mf_done in START must be ignored.
    words[0] = 8'd3; words[1] = 8'd9; words[2] = 8'd1; words[3] = 8'd7; words[4] = 8'd4;
    run_load(5, 0, 1'b1, 1'b1, 2);

    // Back-pressure pattern 1,0,0,1,0,1 over three words.
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3;
    run_load(3, -1, 1'b1, 1'b0, 0);

    // Checksum vector 0xF0+0x20+0x05 = 0x15 (mod 256).
    words[0] = 8'hF0; words[1] = 8'h20; words[2] = 8'h05;
    run_load(3, 0, 1'b1, 1'b0, 0);

    // Reset in the middle of a load, after three accepts.
    load_go = 1'b1;
    step();
    load_go = 1'b0;
    in_valid = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = DATA_W'(8'h40 + i);
      step();
    end
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_last_addr", last_addr, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("midrst_checksum", checksum, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    words[0] = 8'h5A; words[1] = 8'hC3;
    run_load(2, 0, 1'b1, 1'b0, 0);

    // Randomised sets: lengths past 16 exercise forced termination.
    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(20, 1);
      for (int i = 0; i < 32; i++) words[i] = DATA_W'($urandom);
      run_load(len, $urandom_range(60), 1'($urandom_range(1)),
               1'($urandom_range(1)), $urandom_range(3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
